// File: rtl/nn_output_drain_pkg.sv
// -----------------------------------------------------------------------------
// nn_output_drain_pkg
//   Shared definitions for the output-channel drain and its argmax tracker:
//     - drain_state_t : drain FSM state encoding
//     - addr_w_for()  : channel address width for a given depth (clog2, min 1)
//     - most_neg_bits(): bit pattern of the most-negative signed value of a
//                        given width (truncate to the width at the use site)
//     - NN_DATA_W / NN_MOST_NEG : default channel word width and its minimum
// -----------------------------------------------------------------------------
package nn_output_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FINISH  = 3'd4
    } drain_state_t;

    // Address width never drops below one bit so a single-word channel still
    // has a legal address bus.
    function automatic int addr_w_for(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Only bit (width-1) set; the caller truncates to its own word width.
    function automatic logic [63:0] most_neg_bits(input int width);
        return 64'(1) << (width - 1);
    endfunction

    localparam int unsigned NN_DATA_W = 8;
    localparam logic signed [NN_DATA_W-1:0] NN_MOST_NEG =
        NN_DATA_W'(most_neg_bits(NN_DATA_W));

endpackage

// File: rtl/nn_argmax_track.sv
// -----------------------------------------------------------------------------
// nn_argmax_track
//   Registered running maximum / argmax over a stream of signed words.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset (outputs -> 0)
//     clear           restart tracking: max_val <= most-negative, max_idx <= 0
//     load_en         a candidate word is present on data/index this cycle
//     force_load      take the candidate unconditionally (first word)
//     data, index     candidate word and its channel index
//     max_val         largest word seen since the last clear
//     max_idx         index of that word; ties keep the earlier index
// -----------------------------------------------------------------------------
module nn_argmax_track
    import nn_output_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load_en,
    input  logic                     force_load,
    input  logic signed [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]         index,
    output logic signed [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]         max_idx
);

    localparam logic signed [DATA_W-1:0] MOST_NEG = DATA_W'(most_neg_bits(DATA_W));

    // Strict compare so an equal later word never steals the argmax.
    logic take;
    assign take = load_en && (force_load || (data > max_val));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (clear) begin
            max_val <= MOST_NEG;
            max_idx <= '0;
        end else if (take) begin
            max_val <= data;
            max_idx <= index;
        end
    end

endmodule

// File: rtl/nn_output_drain.sv
// -----------------------------------------------------------------------------
// nn_output_drain
//   Drains the network's output-channel memory once per ack_network high
//   period: reads every word, streams it out, and publishes argmax/max.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset (all outputs -> 0)
//     ack_network   level from the last layer; high = outputs valid
//     rd_trig       one-cycle read strobe to the output channel memory
//     rd_abus       read address, meaningful while rd_trig=1
//     rd_dbus       read data, valid the cycle after rd_trig
//     out_valid     stream word valid
//     out_ready     downstream accept
//     out_data      stream word
//     out_index     channel index of out_data
//     out_last      high with the word at index DEPTH-1
//     busy          drain in progress
//     done          sticky result-valid flag (cleared at next drain start)
//     argmax_idx    index of the maximum word
//     max_val       maximum word value
//     state_dbg     current FSM state (drain_state_t encoding)
//
//   Stream handshake: a word transfers on a rising clk edge where
//   out_valid=1 and out_ready=1. Once out_valid rises, out_data, out_index and
//   out_last hold until that transfer; out_valid never drops without one.
//   out_ready is don't-care while out_valid=0.
// -----------------------------------------------------------------------------
module nn_output_drain
    import nn_output_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = addr_w_for(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ack_network,
    output logic                     rd_trig,
    output logic [ADDR_W-1:0]        rd_abus,
    input  logic signed [DATA_W-1:0] rd_dbus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        argmax_idx,
    output logic signed [DATA_W-1:0] max_val,
    output logic [2:0]               state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    drain_state_t      state;
    logic [ADDR_W-1:0] addr;
    logic              armed;

    logic start;
    logic track_load;
    logic track_first;

    assign start       = (state == ST_IDLE) && ack_network && armed;
    assign track_load  = (state == ST_CAPTURE);
    assign track_first = (addr == '0);

    assign rd_abus   = addr;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            armed     <= 1'b1;
            rd_trig   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Re-arm on any low ack, even mid-drain, so the next high period
            // starts exactly one new drain.
            if (!ack_network) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        armed   <= 1'b0;
                        addr    <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        rd_trig <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    rd_trig <= 1'b0;
                    state   <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    out_data  <= rd_dbus;
                    out_index <= addr;
                    out_last  <= (addr == LAST_ADDR);
                    out_valid <= 1'b1;
                    state     <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            // out_last guards the top address, so this
                            // increment never reaches DEPTH.
                            addr    <= addr + ADDR_W'(1);
                            rd_trig <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_FINISH: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Cleared on the same edge the drain starts; loads from rd_dbus during
    // CAPTURE, with the first word taken unconditionally.
    nn_argmax_track #(
        .DATA_W (DATA_W),
        .IDX_W  (ADDR_W)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .load_en    (track_load),
        .force_load (track_first),
        .data       (rd_dbus),
        .index      (addr),
        .max_val    (max_val),
        .max_idx    (argmax_idx)
    );

endmodule
